// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer states, nibble width and counter sizing.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    // Counter width needed to index WIDTH/4 nibbles (never below 1 bit).
    function automatic int cnt_width(input int width);
        return (width / NIBBLE_W > 1) ? $clog2(width / NIBBLE_W) : 1;
    endfunction

endpackage

// File: rtl/four_bit_adder.sv
// Four-bit ripple adder slice with carry in/out.
module four_bit_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] Sum,
    output logic       cout
);

    assign {cout, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract built from one four_bit_adder slice reused over
// WIDTH/4 cycles, least-significant nibble first, with a start/busy/done handshake.
module nibble_serial_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH / NIBBLE_W - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_sum_nib;
    logic                w_cout;

    assign w_a_nib = r_a[{r_cnt, 2'b00} +: NIBBLE_W];
    assign w_b_nib = r_b[{r_cnt, 2'b00} +: NIBBLE_W];

    four_bit_adder u_slice (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .cin  (r_carry),
        .Sum  (w_sum_nib),
        .cout (w_cout)
    );

    // NOTE: every register here uses <= so all state updates see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1: invert B once here, seed carry with 1.
                        r_a     <= a;
                        r_b     <= b ^ {WIDTH{sub}};
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_sum[{r_cnt, 2'b00} +: NIBBLE_W] <= w_sum_nib;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cout  <= w_cout;
                        // Operand signs agree but the result sign differs.
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_sum_nib[NIBBLE_W-1] != r_a[WIDTH-1]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed table, random ops
// against an arithmetic model, back-to-back starts and mid-operation reset.
module tb_nibble_serial_adder;

    localparam int WIDTH    = 32;
    localparam int DONE_CYC = WIDTH / 4 + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned/signed arithmetic on the full operands.
    function automatic void model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic s, output logic [WIDTH-1:0] rs,
                                  output logic rc, output logic ro);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r;
        if (!s) begin
            {rc, rs} = {1'b0, x} + {1'b0, y};
            r = sx + sy;
        end else begin
            rs = x - y;
            rc = (x >= y);
            r  = sx - sy;
        end
        ro = (r > 64'sh7FFF_FFFF) || (r < -64'sh8000_0000);
    endfunction

    task automatic run_op(input string name, input logic [WIDTH-1:0] ta,
                          input logic [WIDTH-1:0] tb_v, input logic ts,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int done_cyc = 0;
        int busy_cnt = 0;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20 && done_cyc == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (done) done_cyc = k;
            else if (busy) busy_cnt++;
        end
        check({name, " latency"}, 64'(done_cyc), 64'(DONE_CYC));
        check({name, " busy_cycles"}, 64'(busy_cnt), 64'(DONE_CYC - 1));
        check({name, " result"}, {29'b0, busy, eo, ec, sum}, {29'b0, 1'b0, eo, ec, es});
        @(negedge clk);
        check({name, " hold"}, {30'b0, done, cout, sum}, {30'b0, 1'b0, ec, es});
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb, rs, cap_a, cap_b;
        logic             rsub, rc, ro, cap_s;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h1234_5678, 32'h0000_0000, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything stays zero.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_zero", {29'b0, busy, done, cout, overflow, sum}, 64'd0);
        end

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rsub = 1'($urandom_range(1));
            if (i == 3) rb = ra;
            model(ra, rb, rsub, rs, rc, ro);
            run_op($sformatf("rand%0d", i), ra, rb, rsub, rs, rc, ro);
        end

        // start held high: operands change every cycle, only DONE-cycle values are taken.
        @(negedge clk);
        cap_a = $urandom; cap_b = $urandom; cap_s = 1'b0;
        a = cap_a; b = cap_b; sub = cap_s; start = 1'b1;
        for (int cyc = 1; cyc <= 3 * DONE_CYC; cyc++) begin
            @(negedge clk);
            if (cyc % DONE_CYC == 0) begin
                model(cap_a, cap_b, cap_s, rs, rc, ro);
                check($sformatf("b2b_done%0d", cyc), {61'b0, busy, done}, 64'd1);
                check($sformatf("b2b_res%0d", cyc), {31'b0, ro, rc, sum}, {31'b0, ro, rc, rs});
            end else begin
                check($sformatf("b2b_busy%0d", cyc), {62'b0, busy, done}, 64'd2);
            end
            a = $urandom; b = $urandom; sub = 1'($urandom_range(1));
            if (cyc % DONE_CYC == 0) begin
                cap_a = a; cap_b = b; cap_s = sub;
                if (cyc == 3 * DONE_CYC) start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle", {62'b0, busy, done}, 64'd0);

        // Reset in RUN cycle 4: asynchronous clear, no done afterwards.
        @(negedge clk);
        a = 32'hDEAD_BEEF; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_busy", {63'b0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_async", {29'b0, busy, done, cout, overflow, sum}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_held", {29'b0, busy, done, cout, overflow, sum}, 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < DONE_CYC + 2; i++) begin
            @(negedge clk);
            check("rst_no_done", {62'b0, busy, done}, 64'd0);
        end
        run_op("post_rst", 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
